rca_seq_nb: RTL and testbench

RCA_SEQ_NB -- requirements
Module: rca_seq_nb

---
 rtl/rca_seq_nb.sv | 129 ++++++++++++
 tb/tb_rca_seq_nb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_nb.sv
// Sequential ripple-carry adder/subtractor: adds one k-bit digit per cycle, so the result lands n/k cycles after start.
// Start is ignored while busy. Results stay on sum/co/ovf until the next accepted start.
module rca_seq_nb #(
  parameter int n = 8,
  parameter int k = 4   // must divide n
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] sum,
  output logic         co,
  output logic         ovf
);

  localparam int D  = n / k;
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [n-1:0]    a_q, a_d;
  logic [n-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [n-1:0]    sum_q, sum_d;
  logic            co_q, co_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [k-1:0]    a_dig;
  logic [k-1:0]    b_dig;
  logic [k:0]      dsum;

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < D; i++) begin
      if (cnt_q == CW'(i)) begin
        a_dig = a_q[i*k +: k];
        b_dig = b_q[i*k +: k];
      end
    end
  end

  assign dsum = {1'b0, a_dig} + {1'b0, b_dig} + {{k{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    if (start && (state_q != RUN)) begin
      // Subtraction is a + ~b with the carry-in inverted.
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = cin ^ sub;
      cnt_d   = '0;
      sum_d   = '0;
      co_d    = 1'b0;
      ovf_d   = 1'b0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          for (int i = 0; i < D; i++) begin
            if (cnt_q == CW'(i)) sum_d[i*k +: k] = dsum[k-1:0];
          end
          carry_d = dsum[k];
          if (cnt_q == CW'(D - 1)) begin
            // Carry into the msb is recovered from the msb sum bit of the last digit.
            co_d    = dsum[k];
            ovf_d   = a_dig[k-1] ^ b_dig[k-1] ^ dsum[k-1] ^ dsum[k];
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_rca_seq_nb.sv
// Bench for rca_seq_nb: three instances (8/4, 16/4, 8/8) checked against a scoreboard of expected results and done times.
module tb_rca_seq_nb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        st0, ci0, sb0, bz0, dn0, co0, ov0;
  logic [7:0]  a0, b0, s0;
  logic        st1, ci1, sb1, bz1, dn1, co1, ov1;
  logic [15:0] a1, b1, s1;
  logic        st2, ci2, sb2, bz2, dn2, co2, ov2;
  logic [7:0]  a2, b2, s2;

  rca_seq_nb #(.n(8), .k(4)) u8 (
    .clk(clk), .rst(rst), .start(st0), .a(a0), .b(b0), .cin(ci0), .sub(sb0),
    .busy(bz0), .done(dn0), .sum(s0), .co(co0), .ovf(ov0));

  rca_seq_nb #(.n(16), .k(4)) u16 (
    .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .cin(ci1), .sub(sb1),
    .busy(bz1), .done(dn1), .sum(s1), .co(co1), .ovf(ov1));

  rca_seq_nb #(.n(8), .k(8)) u88 (
    .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .cin(ci2), .sub(sb2),
    .busy(bz2), .done(dn2), .sum(s2), .co(co2), .ovf(ov2));

  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference: {co,sum} = a + (sub ? ~b : b) + (cin ^ sub); overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input int due);
    logic [31:0] mask, bp, full;
    exp_t e;
    mask  = (32'd1 << w) - 32'd1;
    bp    = (sub ? ~{16'h0, b} : {16'h0, b}) & mask;
    full  = {16'h0, a} + bp + {31'd0, cin ^ sub};
    e.sum = full[15:0] & mask[15:0];
    e.co  = full[w];
    e.ovf = (a[w-1] == bp[w-1]) && (e.sum[w-1] != a[w-1]);
    e.due = due;
    return e;
  endfunction

  task automatic cmp_res(input string tag, input exp_t e, input logic [15:0] s,
                         input logic c, input logic o);
    check({tag, ".sum"}, 32'(s), 32'(e.sum));
    check({tag, ".co"},  32'(c), 32'(e.co));
    check({tag, ".ovf"}, 32'(o), 32'(e.ovf));
    check({tag, ".done_cycle"}, cyc, e.due);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (dn0 === 1'b1) begin
      if (q0.size() == 0) check("u8.unexpected_done", 32'(dn0), 32'd0);
      else begin e = q0.pop_front(); cmp_res("u8", e, {8'h0, s0}, co0, ov0); end
    end
    if (dn1 === 1'b1) begin
      if (q1.size() == 0) check("u16.unexpected_done", 32'(dn1), 32'd0);
      else begin e = q1.pop_front(); cmp_res("u16", e, s1, co1, ov1); end
    end
    if (dn2 === 1'b1) begin
      if (q2.size() == 0) check("u88.unexpected_done", 32'(dn2), 32'd0);
      else begin e = q2.pop_front(); cmp_res("u88", e, {8'h0, s2}, co2, ov2); end
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic go0(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                     input bit push);
    st0 = 1'b1; a0 = a; b0 = b; ci0 = c; sb0 = s;
    if (push) q0.push_back(model(8, {8'h0, a}, {8'h0, b}, c, s, cyc + 1 + 2));
  endtask

  task automatic go1(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    st1 = 1'b1; a1 = a; b1 = b; ci1 = c; sb1 = s;
    q1.push_back(model(16, a, b, c, s, cyc + 1 + 4));
  endtask

  task automatic go2(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    st2 = 1'b1; a2 = a; b2 = b; ci2 = c; sb2 = s;
    q2.push_back(model(8, {8'h0, a}, {8'h0, b}, c, s, cyc + 1 + 1));
  endtask

  task automatic chk_zero(input string tag, input logic bz, input logic dn,
                          input logic [15:0] s, input logic c, input logic o);
    check({tag, ".busy"}, 32'(bz), 32'd0);
    check({tag, ".done"}, 32'(dn), 32'd0);
    check({tag, ".sum"},  32'(s),  32'd0);
    check({tag, ".co"},   32'(c),  32'd0);
    check({tag, ".ovf"},  32'(o),  32'd0);
  endtask

  initial begin
    rst = 1'b1;
    st0 = 1'b0; a0 = '0; b0 = '0; ci0 = 1'b0; sb0 = 1'b0;
    st1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; sb1 = 1'b0;
    st2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; sb2 = 1'b0;
    step();
    chk_zero("rst.u8",  bz0, dn0, {8'h0, s0}, co0, ov0);
    chk_zero("rst.u16", bz1, dn1, s1, co1, ov1);
    chk_zero("rst.u88", bz2, dn2, {8'h0, s2}, co2, ov2);

    // 0x7F + 0x01 on the first edge after reset; busy for exactly two cycles
    rst = 1'b0;
    go0(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    step();
    st0 = 1'b0;
    check("t1.busy_c1", 32'(bz0), 32'd1);
    step();
    check("t1.busy_c2", 32'(bz0), 32'd1);
    step();
    check("t1.busy_done", 32'(bz0), 32'd0);
    check("t1.done", 32'(dn0), 32'd1);
    step();
    check("t1.done_one_cycle", 32'(dn0), 32'd0);
    check("t1.sum_hold", 32'(s0), 32'h80);

    go0(8'hFF, 8'h01, 1'b1, 1'b0, 1'b1);
    step(); st0 = 1'b0; run(3);

    go0(8'h05, 8'h07, 1'b0, 1'b1, 1'b1);
    step(); st0 = 1'b0; run(3);
    go0(8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
    step(); st0 = 1'b0; run(3);

    // Start pulsed during RUN with other operands must be ignored
    go0(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    step();
    go0(8'h55, 8'h66, 1'b1, 1'b1, 1'b0);
    step(); st0 = 1'b0; run(4);

    // Start held through DONE: second operation begins straight from DONE
    go0(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b1);
    run(3);
    go0(8'h10, 8'h20, 1'b1, 1'b1, 1'b1);
    step();
    st0 = 1'b0;
    check("b2b.busy_from_done", 32'(bz0), 32'd1);
    run(4);

    // Reset in the cycle after start aborts with no done pulse
    go0(8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    step();
    st0 = 1'b0; rst = 1'b1;
    step();
    chk_zero("abort.u8", bz0, dn0, {8'h0, s0}, co0, ov0);
    rst = 1'b0;
    run(4);

    // Single-digit configuration: done one cycle after start
    go2(8'hFF, 8'hFF, 1'b1, 1'b0);
    step();
    st2 = 1'b0;
    check("k8.busy", 32'(bz2), 32'd1);
    step();
    check("k8.busy_done", 32'(bz2), 32'd0);
    go2(8'h80, 8'h7F, 1'b1, 1'b1);
    step(); st2 = 1'b0; run(2);
    go2(8'h7F, 8'h7F, 1'b0, 1'b0);
    step(); st2 = 1'b0; run(2);

    // Random sweep on the 16-bit, four-digit instance
    for (int i = 0; i < 1000; i++) begin
      go1(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      step();
      st1 = 1'b0;
      run(4);
    end

    run(3);
    check("u8.queue_empty",  q0.size(), 32'd0);
    check("u16.queue_empty", q1.size(), 32'd0);
    check("u88.queue_empty", q2.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
